// File: rtl/led_bar_pwm.sv
// LED bar renderer for the 4-bit counter stage: thermometer bar, PWM dimming,
// and a full-bar flash whenever the upstream count wraps.
module led_bar_pwm #(
  parameter int PWM_BITS  = 4,
  parameter int FLASH_LEN = 2
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic [3:0]          i_level_in,
  input  logic                i_level_vld,
  input  logic [PWM_BITS-1:0] i_brightness,
  output logic [3:0]          o_led_out,
  output logic                o_wrap_pulse,
  output logic                o_flashing
);

  localparam int FC_W = $clog2(FLASH_LEN + 1);

  typedef enum logic {
    S_SHOW  = 1'b0,
    S_FLASH = 1'b1
  } state_t;

  logic [3:0]          r_level_q;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [PWM_BITS-1:0] r_bright_q;
  state_t              r_state;
  logic [FC_W-1:0]     r_flash_cnt;
  logic [3:0]          r_led_out;
  logic                r_wrap_pulse;

  logic [3:0]          w_mask;
  logic                w_pwm_wrap;
  logic                w_pwm_on;
  logic                w_wrap_det;
  state_t              w_state_next;
  logic [FC_W-1:0]     w_flash_cnt_next;
  logic [3:0]          w_led_next;

  // Segment gi lights once the level exceeds 4*gi.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_mask
      assign w_mask[gi] = (r_level_q > 4'(4 * gi));
    end
  endgenerate

  assign w_pwm_wrap = (r_pwm_cnt == {PWM_BITS{1'b1}});
  assign w_pwm_on   = (r_bright_q == {PWM_BITS{1'b1}}) || (r_pwm_cnt < r_bright_q);
  assign w_wrap_det = i_level_vld && (i_level_in < r_level_q);

  always_comb begin
    w_state_next     = r_state;
    w_flash_cnt_next = r_flash_cnt;
    w_led_next       = 4'b0000;
    case (r_state)
      S_SHOW: begin
        if (w_pwm_on) w_led_next = w_mask;
      end
      S_FLASH: begin
        if (w_pwm_on) w_led_next = 4'b1111;
        if (w_pwm_wrap) begin
          if (r_flash_cnt == FC_W'(FLASH_LEN - 1)) begin
            w_state_next     = S_SHOW;
            w_flash_cnt_next = '0;
          end else begin
            w_flash_cnt_next = r_flash_cnt + 1'b1;
          end
        end
      end
      default: w_state_next = S_SHOW;
    endcase
    // A new wrap always (re)starts the flash, even on a PWM period boundary.
    if (w_wrap_det) begin
      w_state_next     = S_FLASH;
      w_flash_cnt_next = '0;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_level_q    <= 4'd0;
      r_pwm_cnt    <= '0;
      r_bright_q   <= '0;
      r_state      <= S_SHOW;
      r_flash_cnt  <= '0;
      r_led_out    <= 4'b0000;
      r_wrap_pulse <= 1'b0;
    end else begin
      r_pwm_cnt    <= r_pwm_cnt + 1'b1;
      if (w_pwm_wrap) r_bright_q <= i_brightness;
      if (i_level_vld) r_level_q <= i_level_in;
      r_state      <= w_state_next;
      r_flash_cnt  <= w_flash_cnt_next;
      r_led_out    <= w_led_next;
      r_wrap_pulse <= w_wrap_det;
    end
  end

  assign o_led_out    = r_led_out;
  assign o_wrap_pulse = r_wrap_pulse;
  assign o_flashing   = (r_state == S_FLASH);

endmodule

// File: tb/tb_led_bar_pwm.sv
// Directed bench for led_bar_pwm (PWM_BITS=4, FLASH_LEN=2); ph counts clock
// edges since the last reset release, so PWM phase is known to the bench.
module tb_led_bar_pwm;

  logic       clk = 1'b0;
  logic       n_rst;
  logic [3:0] i_level_in;
  logic       i_level_vld;
  logic [3:0] i_brightness;
  logic [3:0] o_led_out;
  logic       o_wrap_pulse;
  logic       o_flashing;

  int n_checks = 0;
  int n_errors = 0;
  int ph = 0;

  logic [3:0] bar_lvl [9] = '{4'd0, 4'd1, 4'd4, 4'd5, 4'd8, 4'd9, 4'd12, 4'd13, 4'd15};
  logic [3:0] bar_exp [9] = '{4'b0000, 4'b0001, 4'b0001, 4'b0011, 4'b0011,
                              4'b0111, 4'b0111, 4'b1111, 4'b1111};

  led_bar_pwm #(.PWM_BITS(4), .FLASH_LEN(2)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .i_level_in   (i_level_in),
    .i_level_vld  (i_level_vld),
    .i_brightness (i_brightness),
    .o_led_out    (o_led_out),
    .o_wrap_pulse (o_wrap_pulse),
    .o_flashing   (o_flashing)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // One clock edge; returns at the following falling edge, where outputs are sampled.
  task automatic tick();
    @(posedge clk);
    ph++;
    @(negedge clk);
  endtask

  // Advance until the last edge was a PWM wrap (bright_q load edge).
  task automatic sync_period();
    do tick(); while (ph % 16 != 0);
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    ph = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] exp_led;
    logic       exp_wrap;
    logic       exp_flash;
    int         on_cnt;

    // Reset held with active-looking inputs.
    n_rst = 1'b0;
    i_level_in = 4'd9;
    i_level_vld = 1'b1;
    i_brightness = 4'd15;
    @(negedge clk);
    tick(); tick(); tick();
    check_eq("rst_led", o_led_out, 4'b0000);
    check_eq("rst_wrap", o_wrap_pulse, 1'b0);
    check_eq("rst_flash", o_flashing, 1'b0);

    // First sample 0 after reset, then 7 repeated: never a wrap.
    i_level_in = 4'd0;
    n_rst = 1'b1;
    ph = 0;
    for (int e = 1; e <= 17; e++) begin
      i_level_in = (e == 1) ? 4'd0 : 4'd7;
      i_level_vld = 1'b1;
      tick();
      check_eq($sformatf("nowrap_wrap_e%0d", e), o_wrap_pulse, 1'b0);
      check_eq($sformatf("nowrap_flash_e%0d", e), o_flashing, 1'b0);
      check_eq($sformatf("nowrap_led_e%0d", e), o_led_out, (e <= 16) ? 4'b0000 : 4'b0011);
    end

    // Bar map at full brightness.
    do_reset();
    i_level_vld = 1'b0;
    i_brightness = 4'd15;
    sync_period();
    for (int k = 0; k < 9; k++) begin
      i_level_in = bar_lvl[k];
      i_level_vld = 1'b1;
      tick();
      if (k > 0) check_eq($sformatf("bar_lvl%0d", bar_lvl[k-1]), o_led_out, bar_exp[k-1]);
    end
    i_level_vld = 1'b0;
    tick();
    check_eq("bar_lvl15_last", o_led_out, bar_exp[8]);

    // Duty 4/16 with level 15.
    i_brightness = 4'd4;
    sync_period();
    for (int i = 0; i < 16; i++) begin
      tick();
      check_eq($sformatf("duty4_c%0d", i), o_led_out, (i < 4) ? 4'b1111 : 4'b0000);
    end

    // Brightness 0 keeps the bar dark for a whole period.
    i_brightness = 4'd0;
    sync_period();
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (o_led_out != 4'b0000) on_cnt++;
    end
    check_eq("duty0_on_cycles", on_cnt, 0);

    // 4 -> 8 change mid-period only lands at the next period.
    i_brightness = 4'd4;
    sync_period();
    for (int i = 0; i < 32; i++) begin
      if (i == 8) i_brightness = 4'd8;
      tick();
      exp_led = ((i < 16) ? (i < 4) : ((i - 16) < 8)) ? 4'b1111 : 4'b0000;
      check_eq($sformatf("duty_chg_c%0d", i), o_led_out, exp_led);
    end

    // Wrap flash, retrigger on a PWM wrap edge, then a flash cut by async reset.
    do_reset();
    i_level_vld = 1'b0;
    i_brightness = 4'd15;
    sync_period();
    for (int e = 17; e <= 99; e++) begin
      i_level_vld = 1'b1;
      case (e)
        17: i_level_in = 4'd10;
        18: i_level_in = 4'd2;
        50: i_level_in = 4'd10;
        51: i_level_in = 4'd2;
        63: i_level_in = 4'd9;
        64: i_level_in = 4'd1;
        98: i_level_in = 4'd5;
        99: i_level_in = 4'd3;
        default: i_level_vld = 1'b0;
      endcase
      tick();
      exp_wrap  = (e == 18) || (e == 51) || (e == 64) || (e == 99);
      exp_flash = (e >= 18 && e <= 47) || (e >= 51 && e <= 95) || (e == 99);
      if (e == 17)                                      exp_led = 4'b0000;
      else if (e == 18 || e == 51)                      exp_led = 4'b0111;
      else if ((e >= 19 && e <= 48) || (e >= 52 && e <= 96)) exp_led = 4'b1111;
      else if (e == 99)                                 exp_led = 4'b0011;
      else                                              exp_led = 4'b0001;
      check_eq($sformatf("flash_wrap_e%0d", e), o_wrap_pulse, exp_wrap);
      check_eq($sformatf("flash_state_e%0d", e), o_flashing, exp_flash);
      check_eq($sformatf("flash_led_e%0d", e), o_led_out, exp_led);
    end
    i_level_vld = 1'b0;
    n_rst = 1'b0;
    #1;
    check_eq("async_rst_led", o_led_out, 4'b0000);
    check_eq("async_rst_wrap", o_wrap_pulse, 1'b0);
    check_eq("async_rst_flash", o_flashing, 1'b0);
    #1;
    n_rst = 1'b1;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
